fc_argmax_seq: RTL and testbench

- Sequential classifier stage directly downstream of the fc2 neuron layers.
- Takes the NCLASS post-ReLU neuron outputs (one `layer` instance per class) and snapshots them on `start`.
- Scans one class per clock, then reports the winning class index and its score with a one-cycle `done` pulse.
- Replaces a wide combinational comparator tree with a single comparator plus a counter.

---
 rtl/fc_pkg.sv | 18 +
 rtl/fc_argmax_step.sv | 27 ++
 rtl/fc_argmax_seq.sv | 98 +++++++++
 tb/tb_fc_argmax_seq.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
// Shared types and width helpers for the fc classifier stages.
package fc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1
    } state_t;

    // Score width: full product width plus accumulation growth over the fan-in.
    function automatic int score_w(input int width, input int in);
        return width * 2 + $clog2(in);
    endfunction

    function automatic int idx_w(input int nclass);
        return (nclass > 1) ? $clog2(nclass) : 1;
    endfunction

endpackage

// File: rtl/fc_argmax_step.sv
// Single argmax step: strict unsigned greater-than compare with a {val, idx} mux.
module argmax_step #(
    parameter int ZW = 23,
    parameter int IW = 4
) (
    input  logic [ZW-1:0] best_val,
    input  logic [IW-1:0] best_idx,
    input  logic [ZW-1:0] cand_val,
    input  logic [IW-1:0] cand_idx,
    output logic [ZW-1:0] out_val,
    output logic [IW-1:0] out_idx
);

    // Strict compare so that on ties the earlier (lower) index is kept.
    always_comb begin
        out_val = best_val;
        out_idx = best_idx;
        if (cand_val > best_val) begin
            out_val = cand_val;
            out_idx = cand_idx;
        end else begin
            out_val = best_val;
            out_idx = best_idx;
        end
    end

endmodule

// File: rtl/fc_argmax_seq.sv
// Sequential argmax over NCLASS snapshotted scores: one class per clock, one-cycle done pulse.
module fc_argmax_seq
    import fc_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int IN     = 128,
    parameter int NCLASS = 10,
    localparam int ZW    = score_w(WIDTH, IN),
    localparam int IW    = idx_w(NCLASS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [ZW-1:0] z [0:NCLASS-1],
    output logic          busy,
    output logic          done,
    output logic [IW-1:0] class_idx,
    output logic [ZW-1:0] max_val
);

    localparam logic [IW-1:0] LAST_IDX = IW'(NCLASS - 1);

    state_t        state_r;
    logic [ZW-1:0] bank_r [0:NCLASS-1];
    logic [ZW-1:0] best_r;
    logic [IW-1:0] bidx_r;
    logic [IW-1:0] cnt_r;
    logic [ZW-1:0] step_val_s;
    logic [IW-1:0] step_idx_s;

    argmax_step #(
        .ZW(ZW),
        .IW(IW)
    ) u_step (
        .best_val(best_r),
        .best_idx(bidx_r),
        .cand_val(bank_r[cnt_r]),
        .cand_idx(cnt_r),
        .out_val (step_val_s),
        .out_idx (step_idx_s)
    );

    // Control FSM, snapshot bank and registered result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            best_r    <= {ZW{1'b0}};
            bidx_r    <= {IW{1'b0}};
            cnt_r     <= {IW{1'b0}};
            busy      <= 1'b0;
            done      <= 1'b0;
            class_idx <= {IW{1'b0}};
            max_val   <= {ZW{1'b0}};
            for (int i = 0; i < NCLASS; i++) begin
                bank_r[i] <= {ZW{1'b0}};
            end
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        bank_r  <= z;
                        best_r  <= z[0];
                        bidx_r  <= {IW{1'b0}};
                        cnt_r   <= IW'(1);
                        busy    <= 1'b1;
                        state_r <= SCAN;
                    end else begin
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                SCAN: begin
                    best_r <= step_val_s;
                    bidx_r <= step_idx_s;
                    // The last comparison feeds the outputs directly, saving a cycle.
                    if (cnt_r == LAST_IDX) begin
                        class_idx <= step_idx_s;
                        max_val   <= step_val_s;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        cnt_r     <= {IW{1'b0}};
                        state_r   <= IDLE;
                    end else begin
                        cnt_r   <= cnt_r + IW'(1);
                        state_r <= SCAN;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    cnt_r   <= {IW{1'b0}};
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fc_argmax_seq.sv
// Randomized bench for fc_argmax_seq with a transaction-level argmax reference model.
module tb_fc_argmax_seq;

    localparam int WIDTH  = 8;
    localparam int IN     = 128;
    localparam int NCLASS = 10;
    localparam int ZW     = 23;
    localparam int IW     = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [ZW-1:0] z [0:NCLASS-1];
    logic          busy;
    logic          done;
    logic [IW-1:0] class_idx;
    logic [ZW-1:0] max_val;

    int vectors = 0;
    int errors  = 0;

    // Reference model state
    int            m_left = 0;
    int            m_pidx = 0;
    logic [ZW-1:0] m_pval = '0;
    logic          e_busy = 1'b0;
    logic          e_done = 1'b0;
    logic [IW-1:0] e_idx  = '0;
    logic [ZW-1:0] e_val  = '0;

    always #5 clk = ~clk;

    fc_argmax_seq #(.WIDTH(WIDTH), .IN(IN), .NCLASS(NCLASS)) dut (
        .clk(clk), .rst(rst), .start(start), .z(z),
        .busy(busy), .done(done), .class_idx(class_idx), .max_val(max_val)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a request accepted while idle yields its argmax NCLASS-1 edges later.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left = 0; e_busy = 1'b0; e_done = 1'b0; e_idx = '0; e_val = '0;
        end else begin
            e_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    e_done = 1'b1; e_busy = 1'b0;
                    e_idx = IW'(m_pidx); e_val = m_pval;
                end
            end else if (start) begin
                m_pidx = 0; m_pval = z[0];
                for (int i = 1; i < NCLASS; i++)
                    if (z[i] > m_pval) begin m_pval = z[i]; m_pidx = i; end
                m_left = NCLASS - 1;
                e_busy = 1'b1;
            end
        end
    end

    // Compare every cycle away from the active edge.
    always @(negedge clk) begin
        chk("busy", 32'(busy), 32'(e_busy));
        chk("done", 32'(done), 32'(e_done));
        chk("class_idx", 32'(class_idx), 32'(e_idx));
        chk("max_val", 32'(max_val), 32'(e_val));
    end

    task automatic step(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic pulse_start();
        start = 1'b1; step(1); start = 1'b0;
    endtask

    task automatic wait_done(input int max, output int cycles);
        cycles = -1;
        for (int i = 0; i < max; i++) begin
            step(1);
            if (done) begin cycles = i + 1; return; end
        end
        chk("done_timeout", 32'(0), 32'(1));
    endtask

    task automatic rand_z(input int maxv);
        for (int i = 0; i < NCLASS; i++) z[i] = ZW'($urandom_range(0, maxv));
    endtask

    initial begin
        int cyc;
        int ndone;
        rst = 1'b1; start = 1'b0;
        for (int i = 0; i < NCLASS; i++) z[i] = '0;
        step(2);
        chk("reset_busy", 32'(busy), 32'(0));
        chk("reset_idx", 32'(class_idx), 32'(0));
        rst = 1'b0;
        step(2);

        // Basic argmax and latency
        z = '{23'd5, 23'd90, 23'd3, 23'd7, 23'd1, 23'd0, 23'd44, 23'd2, 23'd89, 23'd6};
        pulse_start();
        chk("busy_after_start", 32'(busy), 32'(1));
        wait_done(20, cyc);
        chk("latency", 32'(cyc), 32'(NCLASS - 1));
        chk("basic_idx", 32'(class_idx), 32'(1));
        chk("basic_val", 32'(max_val), 32'(90));
        step(1);
        chk("done_one_cycle", 32'(done), 32'(0));
        chk("hold_idx", 32'(class_idx), 32'(1));

        // Reset mid-scan aborts with no done
        rand_z(32'h3FFFFF);
        pulse_start();
        step(3);
        rst = 1'b1; step(1); rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_val", 32'(max_val), 32'(0));
        ndone = 0;
        for (int i = 0; i < 12; i++) begin step(1); if (done) ndone++; end
        chk("abort_no_done", 32'(ndone), 32'(0));

        // All zero
        for (int i = 0; i < NCLASS; i++) z[i] = '0;
        pulse_start(); wait_done(20, cyc);
        chk("zero_idx", 32'(class_idx), 32'(0));
        chk("zero_val", 32'(max_val), 32'(0));

        // Tie: lowest index wins
        for (int i = 0; i < NCLASS; i++) z[i] = ZW'(i * 10);
        z[3] = 23'd1000; z[7] = 23'd1000;
        pulse_start(); wait_done(20, cyc);
        chk("tie_idx", 32'(class_idx), 32'(3));
        chk("tie_val", 32'(max_val), 32'(1000));

        // Last element, maximum magnitude
        for (int i = 0; i < NCLASS; i++) z[i] = 23'd100;
        z[9] = 23'h3FFFFF;
        pulse_start(); wait_done(20, cyc);
        chk("last_idx", 32'(class_idx), 32'(9));
        chk("last_val", 32'(max_val), 32'h3FFFFF);

        // Snapshot isolation and start-while-busy ignored
        z = '{23'd1, 23'd2, 23'd3, 23'd4, 23'd500, 23'd6, 23'd7, 23'd8, 23'd9, 23'd10};
        pulse_start();
        step(2);
        for (int i = 0; i < NCLASS; i++) z[i] = 23'd7;
        z[8] = 23'd9999;
        pulse_start();
        wait_done(20, cyc);
        chk("snap_idx", 32'(class_idx), 32'(4));
        chk("snap_val", 32'(max_val), 32'(500));
        ndone = 0;
        for (int i = 0; i < 15; i++) begin step(1); if (done) ndone++; end
        chk("snap_no_second_done", 32'(ndone), 32'(0));

        // Back-to-back with start held high
        rand_z(32'h3FFFFF);
        start = 1'b1;
        ndone = 0;
        for (int i = 0; i < 30; i++) begin
            step(1);
            if (done) begin ndone++; rand_z(32'h3FFFFF); end
            else if (i % 10 == 1) rand_z(32'h3FFFFF);
        end
        start = 1'b0;
        chk("b2b_done_count", 32'(ndone), 32'(3));
        step(12);

        // Random transactions, small ranges to provoke ties, with start noise
        for (int t = 0; t < 40; t++) begin
            rand_z((t % 2 == 0) ? 7 : 32'h3FFFFF);
            pulse_start();
            for (int i = 0; i < $urandom_range(0, 12); i++) begin
                start = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 1) == 1) rand_z(32'h3FFFFF);
                step(1);
            end
            start = 1'b0;
            step(12);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
